// File: rtl/imem_loader_if.sv
// Byte-stream input, reload request, instruction-memory write port and
// load-status outputs of the instruction-memory loader, bundled as one bus.
interface imem_loader_if #(
    parameter int AW = 10
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          reload;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          load_err;

    // Loader side: consumes the byte stream, drives memory and status.
    modport slave (
        input  in_data, in_valid, reload,
        output in_ready, im_we, im_addr, im_wdata, cpu_reset, load_done, load_err
    );

    // Host side: produces the byte stream, observes memory and status.
    modport master (
        output in_data, in_valid, reload,
        input  in_ready, im_we, im_addr, im_wdata, cpu_reset, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, XOR-checksummed
// byte frame, writes the assembled 32-bit words into instruction memory and
// holds the CPU in reset until a load completes with a good checksum.
module imem_loader #(
    parameter int AW      = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic          clk,
    input  logic          RESET,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // Idle counter only has to reach TIMEOUT-1 before the abort fires.
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t        r_state;
    state_t        w_next;

    logic [15:0]   r_len;
    logic [1:0]    r_byte_cnt;
    logic [15:0]   r_word_idx;
    logic [31:0]   r_asm;
    logic [7:0]    r_xor;
    logic [TW-1:0] r_tmo_cnt;

    logic          r_im_we;
    logic [AW-1:0] r_im_addr;
    logic [31:0]   r_im_wdata;
    logic          r_in_ready;
    logic          r_cpu_reset;
    logic          r_load_done;
    logic          r_load_err;

    logic          w_accept;
    logic          w_timed;
    logic          w_tmo_hit;
    logic [15:0]   w_len_n;
    logic          w_too_long;
    logic          w_last_byte;
    logic          w_last_word;
    logic          w_reenter_idle;
    logic          w_in_ready_nx;
    logic          w_cpu_reset_nx;
    logic          w_load_done_nx;
    logic          w_load_err_nx;

    assign w_accept       = bus.in_valid & r_in_ready;
    assign w_timed        = (r_state == S_LEN_LO) || (r_state == S_DATA) || (r_state == S_CHECK);
    assign w_tmo_hit      = w_timed && !w_accept && (r_tmo_cnt == TW'(TIMEOUT - 1));
    assign w_len_n        = {r_len[15:8], bus.in_data};
    assign w_too_long     = 32'(w_len_n) > (32'd1 << AW);
    assign w_last_byte    = (r_byte_cnt == 2'd3);
    assign w_last_word    = (r_word_idx == (r_len - 16'd1));
    assign w_reenter_idle = (r_state != S_IDLE) && (w_next == S_IDLE);

    // State register; reset overrides reload and any in-flight byte.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode from the current state, handshake and timeout.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned
        // and infers a latch.
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_too_long)           w_next = S_ERROR;
                    else if (w_len_n == 16'd0) w_next = S_CHECK;
                    else                      w_next = S_DATA;
                end else if (w_tmo_hit) begin
                    w_next = S_ERROR;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (w_last_byte && w_last_word) w_next = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_next = S_ERROR;
                end
            end
            S_CHECK: begin
                if (w_accept) begin
                    w_next = (bus.in_data == r_xor) ? S_DONE : S_ERROR;
                end else if (w_tmo_hit) begin
                    w_next = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (bus.reload) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the next state so their registers line up
    // with the state register.
    always_comb begin
        w_in_ready_nx  = (w_next != S_DONE) && (w_next != S_ERROR);
        w_cpu_reset_nx = (w_next != S_DONE);
        w_load_done_nx = (w_next == S_DONE);
        w_load_err_nx  = (w_next == S_ERROR);
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_in_ready  <= 1'b1;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nx;
            r_cpu_reset <= w_cpu_reset_nx;
            r_load_done <= w_load_done_nx;
            r_load_err  <= w_load_err_nx;
        end
    end

    // Frame datapath: length capture, word assembly, checksum, write strobe
    // and idle-cycle counter.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
            r_xor      <= '0;
            r_tmo_cnt  <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
        end else begin
            r_im_we   <= 1'b0;
            r_tmo_cnt <= (w_timed && !w_accept) ? r_tmo_cnt + 1'b1 : '0;
            if (w_reenter_idle) begin
                r_len      <= '0;
                r_byte_cnt <= '0;
                r_word_idx <= '0;
                r_asm      <= '0;
                r_xor      <= '0;
            end else if (w_accept) begin
                case (r_state)
                    S_IDLE:   r_len[15:8] <= bus.in_data;
                    S_LEN_LO: r_len[7:0]  <= bus.in_data;
                    S_DATA: begin
                        r_asm      <= {r_asm[23:0], bus.in_data};
                        r_xor      <= r_xor ^ bus.in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= AW'(r_word_idx);
                            r_im_wdata <= {r_asm[23:0], bus.in_data};
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.im_we     = r_im_we;
    assign bus.im_addr   = r_im_addr;
    assign bus.im_wdata  = r_im_wdata;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.load_done = r_load_done;
    assign bus.load_err  = r_load_err;

endmodule
